// File: rtl/uart_byte_bridge_pkg.sv
// Shared constants and FSM state types for the UART byte bridge.
// simpleuart returns all-ones on reg_dat_do when its receive buffer is empty.
package uart_bridge_pkg;

    localparam logic [31:0] UART_NO_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        R_POLL,
        R_ACK,
        R_SETTLE
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_WRITE,
        T_GAP
    } tx_state_t;

    function automatic logic [31:0] uart_word(input logic [7:0] b);
        return {24'h0, b};
    endfunction

endpackage

// File: rtl/uart_byte_bridge_if.sv
// Bundles the simpleuart register handshake and the RX/TX byte streams.
// The slave modport is the bridge's view; master is the surrounding system's.
interface uart_byte_bridge_if #(
    parameter int RX_AW = 3
);
    logic            uart_re;
    logic            uart_we;
    logic [31:0]     uart_di;
    logic [31:0]     uart_do;
    logic            uart_wait;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [RX_AW:0]  rx_level;
    logic            rx_overflow;

    modport slave (
        output uart_re, uart_we, uart_di, rx_data, rx_valid, tx_ready,
               rx_level, rx_overflow,
        input  uart_do, uart_wait, rx_ready, tx_data, tx_valid
    );

    modport master (
        input  uart_re, uart_we, uart_di, rx_data, rx_valid, tx_ready,
               rx_level, rx_overflow,
        output uart_do, uart_wait, rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_byte_bridge_fifo.sv
// Synchronous FIFO with head-of-queue read data and occupancy output.
// A pop frees the slot in the same cycle, so a full FIFO may push and pop together.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [AW:0]      w_level;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_level   = r_wr - r_rd;
    assign o_level   = w_level;
    assign o_full    = (w_level == FULL_LEVEL);
    assign o_empty   = (r_wr == r_rd);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end
endmodule

// File: rtl/uart_byte_bridge.sv
// Bridges simpleuart's register port to buffered RX and handshaked TX byte streams.
// RX polls, acknowledges and settles per byte; TX holds the write until wait drops.
module uart_byte_bridge
    import uart_bridge_pkg::*;
#(
    parameter int RX_DEPTH = 8,
    parameter int RX_AW    = 3
) (
    input  logic clk,
    input  logic rst,
    uart_byte_bridge_if.slave bus
);
    generate
        if ((RX_DEPTH < 2) || ((1 << RX_AW) != RX_DEPTH)) begin : g_param_check
            $error("uart_byte_bridge: RX_DEPTH must be a power of 2 >= 2 equal to 2**RX_AW");
        end
    endgenerate

    rx_state_t   r_rx_state;
    tx_state_t   r_tx_state;
    logic        r_re;
    logic        r_we;
    logic [31:0] r_di;
    logic        r_tx_ready;
    logic        r_overflow;

    logic        w_has_byte;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;

    assign w_has_byte = (bus.uart_do != UART_NO_DATA);
    assign w_push     = (r_rx_state == R_POLL) && w_has_byte;
    assign w_pop      = bus.rx_ready && !w_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH),
        .AW    (RX_AW)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (bus.uart_do[7:0]),
        .i_pop   (bus.rx_ready),
        .o_rdata (bus.rx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (bus.rx_level)
    );

    // A byte is only lost when the FIFO is full and nothing leaves it this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= R_POLL;
            r_re       <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_rx_state)
                R_POLL: begin
                    if (w_has_byte) begin
                        r_re       <= 1'b1;
                        r_rx_state <= R_ACK;
                        if (w_full && !w_pop) r_overflow <= 1'b1;
                    end
                end
                R_ACK: begin
                    r_re       <= 1'b0;
                    r_rx_state <= R_SETTLE;
                end
                R_SETTLE: r_rx_state <= R_POLL;
                default: begin
                    r_re       <= 1'b0;
                    r_rx_state <= R_POLL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_we       <= 1'b0;
            r_di       <= '0;
            r_tx_ready <= 1'b1;
        end else begin
            case (r_tx_state)
                T_IDLE: begin
                    if (bus.tx_valid) begin
                        r_di       <= uart_word(bus.tx_data);
                        r_we       <= 1'b1;
                        r_tx_ready <= 1'b0;
                        r_tx_state <= T_WRITE;
                    end
                end
                T_WRITE: begin
                    if (!bus.uart_wait) begin
                        r_we       <= 1'b0;
                        r_tx_state <= T_GAP;
                    end
                end
                T_GAP: begin
                    r_tx_ready <= 1'b1;
                    r_tx_state <= T_IDLE;
                end
                default: begin
                    r_we       <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_tx_state <= T_IDLE;
                end
            endcase
        end
    end

    assign bus.uart_re     = r_re;
    assign bus.uart_we     = r_we;
    assign bus.uart_di     = r_di;
    assign bus.tx_ready    = r_tx_ready;
    assign bus.rx_valid    = !w_empty;
    assign bus.rx_overflow = r_overflow;
endmodule
